rayand_arbiter: RTL and testbench
=================================

# rayand_arbiter

Round-robin arbiter and sequencer sharing a single registered rayand (bitwise AND) datapath between N_REQ requesters. Each requester raises a request with two operand vectors. The block grants one requester at a time, latches its operands and runs them through the AND stage. It then returns the result tagged with the requester's index. It sits between client logic and the shared AND unit in the top-level datapath.

## Interface
- N_REQ, 4: number of requesters, 2..16.
- WIDTH, 8: operand/result width in bits.
- ID_W, 2: width of requester index; 2**ID_W >= N_REQ.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  request per requester; bit i = requester i.
- a_bus  input  N_REQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH].
- b_bus  input  N_REQ*WIDTH  operand B, same packing.
- gnt  output  N_REQ  one-hot grant, one-cycle pulse.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle result-valid pulse.
- done_id  output  ID_W  index of requester owning result; valid with done.
- result  output  WIDTH  A & B of granted requester; valid with done.
- op_count  output  16  completed operations, wraps 0xFFFF -> 0.

## Operation
- One clock and one reset. Reset is synchronous and active-high.
- FSM states: IDLE, CALC, DONE.
- IDLE: if req != 0 at clock edge, select the winner round-robin. Pulse gnt[winner] and latch the winner's A, B and index into op_a, op_b and op_id. Go to CALC. If req == 0, stay in IDLE.
- CALC: result <= op_a & op_b, done_id <= op_id, done pulses. Go to DONE. req is ignored.
- DONE: increment op_count and update the priority pointer to winner+1 (mod N_REQ). Go to IDLE. req is ignored.
- Round-robin search starts at the pointer index and ascends with wrap. The first asserted req wins. After reset the pointer is 0.
- Requester protocol:
  - Hold req and operands stable until gnt is seen.
  - Deassert req at or before the edge after gnt, unless it wants another operation.
  - A req still high on return to IDLE is treated as a new request.
- Operands are sampled only on the grant edge. Changes after that edge do not affect the result.
- result and done_id hold their values after done drops, until the next done.

## Timing
- Reset values: gnt=0, busy=0, done=0, done_id=0, result=0, op_count=0, state=IDLE, pointer=0.
- Edge E0 (IDLE, req seen): gnt high during cycle E0..E1, busy high from E0.
- Edge E1: done high during E1..E2, result valid.
- Edge E2: state back to IDLE, busy low, op_count incremented.
- Earliest next grant is at E3. Sustained throughput is one operation per 3 cycles.
- Request-to-grant latency is 1 edge when the block is IDLE. Grant-to-done is 1 cycle.
- Simultaneous requests are resolved by the pointer; no requester waits more than N_REQ grants.
- A single persistent requester is re-granted every 3 cycles.
- rst high at any edge aborts any operation in flight. No done follows, and all outputs take reset values at that edge.
- op_count wraps silently, with no flag.

## Test plan
- Reset: hold rst 2 cycles with req=4'b1111 -> gnt=0, done=0, op_count=0, busy=0.
- Single request: req=4'b0100, A2=8'hF0, B2=8'h3C -> gnt=4'b0100 one edge later, then done=1, done_id=2, result=8'h30, op_count=1.
- Round robin: req=4'b1111 held with distinct operands -> grants in order 0,1,2,3,0 at 3-cycle spacing, with a correct result per done_id.
- Pointer wrap: last winner=3, then req=4'b1001 -> requester 0 granted; next grant goes to 3.
- Operand change after grant: change A1 from 8'hFF to 8'h00 in the cycle after gnt[1] -> result still reflects 8'hFF & B1.
- Reset mid-op: assert rst in CALC -> no done pulse, outputs zero, pointer=0; next req=4'b1010 grants requester 1.

Source files
------------

// File: rtl/rayand_arbiter.sv
// Round-robin arbiter sharing one registered bitwise-AND stage between N_REQ requesters.
// Latency: grant 1 edge after req in IDLE, done 1 cycle after grant, back to IDLE 1 cycle later.
// Backpressure: none. One operation at a time, and req is ignored while busy.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req               per-requester request (bit i = requester i)
//   a_bus, b_bus      packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt               one-hot grant pulse
//   busy              high while an operation is in flight
//   done, done_id     result-valid pulse and owning requester index
//   result            A & B of the granted requester, held until next done
//   op_count          completed operations, wraps silently
module rayand_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_bus,
  input  logic [N_REQ*WIDTH-1:0] b_bus,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic [WIDTH-1:0]       result,
  output logic [15:0]            op_count
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  op_id;
  logic [WIDTH-1:0] op_a, op_b;
  logic [ID_W-1:0]  win;
  logic             win_vld;

  // Round-robin search: first asserted req at or after ptr, wrapping at N_REQ.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win     = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = CALC;
      CALC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      op_id    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      gnt      <= '0;
      done     <= 1'b0;
      done_id  <= '0;
      result   <= '0;
      op_count <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= '0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          // Operands are captured only here; later changes on the bus are ignored.
          if (win_vld) begin
            gnt   <= N_REQ'(1) << win;
            op_a  <= a_bus[win*WIDTH +: WIDTH];
            op_b  <= b_bus[win*WIDTH +: WIDTH];
            op_id <= win;
          end
        end
        CALC: begin
          result  <= op_a & op_b;
          done_id <= op_id;
          done    <= 1'b1;
        end
        DONE: begin
          op_count <= op_count + 16'd1;
          // Pointer moves past the last winner so it gets lowest priority next.
          ptr <= (op_id == ID_W'(N_REQ - 1)) ? '0 : op_id + ID_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rayand_arbiter.sv
module tb_rayand_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a_bus, b_bus;
  logic [3:0]  gnt;
  logic        busy, done;
  logic [1:0]  done_id;
  logic [7:0]  result;
  logic [15:0] op_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: who has priority and how many operations have completed.
  int          model_ptr = 0;
  logic [15:0] model_cnt = 16'd0;

  always #5 clk = ~clk;

  rayand_arbiter #(.N_REQ(4), .WIDTH(8), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .result(result), .op_count(op_count)
  );

  typedef struct {
    logic [3:0]  r;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_id;
    logic [7:0]  exp_res;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [7:0] lane(input logic [31:0] v, input int i);
    return v[i*8 +: 8];
  endfunction

  // One full transaction from an idle block: request, grant, done, return to IDLE.
  task automatic apply_op(input logic [3:0] r, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] a_post, input int exp_id,
                          input logic [7:0] exp_res, input string tag);
    int t;
    logic [3:0] eg;
    eg = 4'b0001 << exp_id;
    req = r; a_bus = a; b_bus = b;
    t = 0;
    do begin @(negedge clk); t++; end while (gnt == 4'b0 && t < 8);
    check({tag, "_gnt"}, 32'(gnt), 32'(eg));
    check({tag, "_busy1"}, 32'(busy), 32'd1);
    req = 4'b0; a_bus = a_post;
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_id"}, 32'(done_id), 32'(exp_id));
    check({tag, "_res"}, 32'(result), 32'(exp_res));
    @(negedge clk);
    model_cnt = model_cnt + 16'd1;
    model_ptr = (exp_id + 1) % 4;
    check({tag, "_busy0"}, 32'(busy), 32'd0);
    check({tag, "_done0"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(result), 32'(exp_res));
    check({tag, "_cnt"}, 32'(op_count), 32'(model_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int   t;

    vt[0] = '{4'b0100, 32'h00F00000, 32'h003C0000, 2, 8'h30};
    vt[1] = '{4'b1000, 32'hC3000000, 32'h5A000000, 3, 8'h42};
    vt[2] = '{4'b1001, 32'hFF0000AA, 32'h0F00000F, 0, 8'h0A};
    vt[3] = '{4'b1001, 32'hFF0000AA, 32'h0F00000F, 3, 8'h0F};
    vt[4] = '{4'b0011, 32'h00001234, 32'h0000FF0F, 0, 8'h04};
    vt[5] = '{4'b0010, 32'h00001234, 32'h0000FF0F, 1, 8'h12};

    // Reset held with all requests up.
    rst = 1'b1; req = 4'b1111; a_bus = 32'hFFFFFFFF; b_bus = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cnt", 32'(op_count), 32'd0);
      check("rst_res", 32'(result), 32'd0);
    end
    rst = 1'b0; req = 4'b0;
    @(negedge clk);
    check("idle_gnt", 32'(gnt), 32'd0);

    // Table: single request, pointer wrap, mixed contention.
    for (int i = 0; i < 6; i++)
      apply_op(vt[i].r, vt[i].a, vt[i].b, vt[i].a, vt[i].exp_id, vt[i].exp_res,
               $sformatf("tbl%0d", i));

    // Operand change after grant: A1 drops to 00 after the grant edge.
    apply_op(4'b0010, 32'h0000FF00, 32'h00005A00, 32'h00000000, 1, 8'h5A, "opchg");

    // Reset while in CALC: no done, outputs cleared, pointer back to 0.
    req = 4'b0100; a_bus = 32'h00FF0000; b_bus = 32'h00770000;
    t = 0;
    do begin @(negedge clk); t++; end while (gnt == 4'b0 && t < 8);
    check("mid_gnt", 32'(gnt), 32'h4);
    rst = 1'b1; req = 4'b0;
    @(negedge clk);
    check("mid_done", 32'(done), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_res", 32'(result), 32'd0);
    check("mid_cnt", 32'(op_count), 32'd0);
    rst = 1'b0; model_ptr = 0; model_cnt = 16'd0;
    @(negedge clk);
    check("mid_nodone", 32'(done), 32'd0);
    apply_op(4'b1010, 32'h00003C00, 32'h00000F00, 32'h00003C00, 1, 8'h0C, "mid_after");

    // Persistent all-request: grants 0,1,2,3,0 every 3 cycles.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; model_ptr = 0; model_cnt = 16'd0;
    req = 4'b1111; a_bus = 32'h81422418; b_bus = 32'hFFFFFFFF;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] eg;
      eg = 4'b0001 << (k % 4);
      t = 0;
      do begin @(negedge clk); t++; end while (gnt == 4'b0 && t < 8);
      check("rr_gnt", 32'(gnt), 32'(eg));
      if (k > 0) check("rr_gap", 32'(t + 1), 32'd3);
      @(negedge clk);
      check("rr_id", 32'(done_id), 32'(k % 4));
      check("rr_res", 32'(result), 32'(lane(a_bus, k % 4) & lane(b_bus, k % 4)));
    end
    req = 4'b0;
    @(negedge clk);
    model_cnt = 16'd5; model_ptr = 1;
    check("rr_cnt", 32'(op_count), 32'd5);
    check("rr_busy", 32'(busy), 32'd0);

    // Randomized traffic against the round-robin model.
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  r;
      logic [31:0] a, b;
      int          w;
      r = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom;
      if (r == 4'b0) begin
        req = 4'b0;
        @(negedge clk);
        check("rnd_nogrant", 32'(gnt), 32'd0);
        check("rnd_idle", 32'(busy), 32'd0);
      end else begin
        w = rr_pick(r, model_ptr);
        apply_op(r, a, b, $urandom, w, lane(a, w) & lane(b, w), $sformatf("rnd%0d", i));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
